// File: rtl/clk_edge_meter_if.sv
// Bundle between a divided-clock source and the edge meter: the slow clock in,
// the edge strobes and measurement results out.
interface clk_edge_meter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             clk_in;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] half_period;
    logic             locked;
    logic             timeout;

    modport master (
        output clk_in,
        input  rise, fall, half_period, locked, timeout
    );

    modport slave (
        input  clk_in,
        output rise, fall, half_period, locked, timeout
    );
endinterface

// File: rtl/clk_edge_meter.sv
// Brings a slow asynchronous clock into the clk domain as rise/fall enables,
// measures its half-period and reports lock and loss of the input.
module clk_edge_meter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned TOL     = 1
) (
    input  logic            clk,
    input  logic            rst,
    clk_edge_meter_if.slave meter
);
    localparam int unsigned DIFF_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ARMED  = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_q, hp_d;

    logic              edge_c;
    logic              within_c;
    logic              expire_c;
    logic [DIFF_W-1:0] diff_c;

    assign edge_c   = sync2_q ^ prev_q;
    // Magnitude is one bit wider than the operands so it can never wrap.
    assign diff_c   = (cnt_q >= hp_q) ? (DIFF_W'(cnt_q) - DIFF_W'(hp_q))
                                      : (DIFF_W'(hp_q) - DIFF_W'(cnt_q));
    assign within_c = (diff_c <= DIFF_W'(TOL));
    assign expire_c = (cnt_q == CNT_W'(TIMEOUT)) && !edge_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEARCH;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            hp_q      <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= meter.clk_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            hp_q      <= hp_d;
        end
    end

    // Next-state, measurement and strobe logic.
    always_comb begin
        state_d   = state_q;
        hp_d      = hp_q;
        timeout_d = 1'b0;
        rise_d    = sync2_q & ~prev_q;
        fall_d    = ~sync2_q & prev_q;

        if (edge_c) begin
            cnt_d = CNT_W'(1);
        end else if (state_q == SEARCH) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            SEARCH: begin
                if (edge_c) begin
                    state_d = ARMED;
                end
            end
            ARMED, TRACK, LOCKED: begin
                if (edge_c) begin
                    hp_d = cnt_q;
                    if (state_q == ARMED) begin
                        state_d = TRACK;
                    end else begin
                        state_d = within_c ? LOCKED : TRACK;
                    end
                end else if (expire_c) begin
                    state_d   = SEARCH;
                    hp_d      = '0;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase

        locked_d = (state_d == LOCKED);
    end

    assign meter.rise        = rise_q;
    assign meter.fall        = fall_q;
    assign meter.half_period = hp_q;
    assign meter.locked      = locked_q;
    assign meter.timeout     = timeout_q;
endmodule

// File: tb/tb_clk_edge_meter.sv
// Drives two meters (TIMEOUT 1000 and 20) from one divided clock and compares
// every cycle against an event-time reference model.
module tb_clk_edge_meter;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TOL   = 1;
    localparam int          TO_A  = 1000;
    localparam int          TO_B  = 20;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clk_in = 1'b0;

    int checks = 0;
    int errors = 0;

    clk_edge_meter_if #(.CNT_W(CNT_W)) bus_a ();
    clk_edge_meter_if #(.CNT_W(CNT_W)) bus_b ();
    assign bus_a.clk_in = clk_in;
    assign bus_b.clk_in = clk_in;

    clk_edge_meter #(.CNT_W(CNT_W), .TIMEOUT(TO_A), .TOL(TOL)) dut_a (
        .clk(clk), .rst(rst), .meter(bus_a.slave));
    clk_edge_meter #(.CNT_W(CNT_W), .TIMEOUT(TO_B), .TOL(TOL)) dut_b (
        .clk(clk), .rst(rst), .meter(bus_b.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: edges are instants in time; intervals, lock and loss follow
    // from the spacing of those instants. Strobes trail clk_in by three clk edges.
    int   t;
    logic hist [4];
    int   m_to_lim [2] = '{TO_A, TO_B};
    bit   m_armed  [2];
    bit   m_meas   [2];
    int   m_last   [2];
    int   m_hp     [2];
    bit   m_locked [2];
    bit   m_to     [2];
    bit   e_rise, e_fall;
    int   a_to_cnt = 0;
    int   b_to_cnt = 0;

    always @(negedge clk) begin
        logic          ev;
        logic [15:0]   g_hp [2];
        logic          g_rise [2], g_fall [2], g_lk [2], g_to [2];
        int            iv, d;
        if (rst) begin
            t = 0;
            for (int k = 0; k < 4; k++) hist[k] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_armed[i] = 0; m_meas[i] = 0; m_last[i] = 0;
                m_hp[i] = 0; m_locked[i] = 0; m_to[i] = 0;
            end
            e_rise = 0; e_fall = 0;
        end else begin
            t++;
            hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = clk_in;
            ev     = hist[2] != hist[3];
            e_rise = hist[2] & ~hist[3];
            e_fall = ~hist[2] & hist[3];
            for (int i = 0; i < 2; i++) begin
                m_to[i] = 0;
                iv = t - m_last[i];
                if (ev) begin
                    if (!m_armed[i]) begin
                        m_armed[i] = 1;
                    end else if (!m_meas[i]) begin
                        m_meas[i] = 1; m_hp[i] = iv; m_locked[i] = 0;
                    end else begin
                        d = (iv > m_hp[i]) ? iv - m_hp[i] : m_hp[i] - iv;
                        m_locked[i] = (d <= int'(TOL));
                        m_hp[i] = iv;
                    end
                    m_last[i] = t;
                end else if (m_armed[i] && iv == m_to_lim[i]) begin
                    m_to[i] = 1; m_armed[i] = 0; m_meas[i] = 0;
                    m_hp[i] = 0; m_locked[i] = 0;
                end
            end
        end
        g_rise[0] = bus_a.rise; g_fall[0] = bus_a.fall; g_hp[0] = bus_a.half_period;
        g_lk[0] = bus_a.locked; g_to[0] = bus_a.timeout;
        g_rise[1] = bus_b.rise; g_fall[1] = bus_b.fall; g_hp[1] = bus_b.half_period;
        g_lk[1] = bus_b.locked; g_to[1] = bus_b.timeout;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rise[%0d]", i), 32'(g_rise[i]), 32'(e_rise));
            check($sformatf("fall[%0d]", i), 32'(g_fall[i]), 32'(e_fall));
            check($sformatf("half_period[%0d]", i), 32'(g_hp[i]), 32'(m_hp[i]));
            check($sformatf("locked[%0d]", i), 32'(g_lk[i]), 32'(m_locked[i]));
            check($sformatf("timeout[%0d]", i), 32'(g_to[i]), 32'(m_to[i]));
        end
        if (bus_a.timeout === 1'b1) a_to_cnt++;
        if (bus_b.timeout === 1'b1) b_to_cnt++;
    end

    // Toggle clk_in n clk periods after the previous toggle, away from posedge.
    task automatic toggle_after(input int n);
        repeat (n) @(negedge clk);
        #2 clk_in = ~clk_in;
    endtask

    initial begin
        int jit [5] = '{5, 6, 5, 4, 5};
        int n;

        repeat (2) @(negedge clk);
        check("reset_hp", 32'(bus_a.half_period), 32'd0);
        check("reset_locked", 32'(bus_a.locked), 32'd0);
        #1 rst = 1'b0;

        // Steady input, then jitter within tolerance, then a step to 9.
        repeat (6) toggle_after(5);
        foreach (jit[k]) toggle_after(jit[k]);
        toggle_after(9);
        toggle_after(9);
        repeat (4) @(negedge clk);
        check("step_hp", 32'(bus_a.half_period), 32'd9);
        check("step_locked", 32'(bus_a.locked), 32'd1);

        // Loss of input while locked.
        a_to_cnt = 0;
        repeat (1100) @(negedge clk);
        check("loss_timeouts", 32'(a_to_cnt), 32'd1);
        check("loss_hp", 32'(bus_a.half_period), 32'd0);
        check("loss_locked", 32'(bus_a.locked), 32'd0);

        // Edges landing exactly on the timeout cycle of the short-timeout meter.
        toggle_after(3);
        b_to_cnt = 0;
        repeat (6) toggle_after(TO_B);
        repeat (4) @(negedge clk);
        check("edge_on_to_count", 32'(b_to_cnt), 32'd0);
        check("edge_on_to_hp", 32'(bus_b.half_period), 32'(TO_B));
        check("edge_on_to_locked", 32'(bus_b.locked), 32'd1);

        // Randomised intervals, occasionally long enough to trip the short timeout.
        repeat (150) begin
            n = int'($urandom_range(14, 2));
            if ($urandom_range(9, 0) == 0) n = int'($urandom_range(40, 15));
            toggle_after(n);
        end

        // Reset mid-lock with clk_in high.
        toggle_after(5);
        if (clk_in == 1'b0) toggle_after(5);
        repeat (4) toggle_after(5);
        repeat (4) @(negedge clk);
        check("prereset_locked", 32'(bus_a.locked), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_rise", 32'(bus_a.rise | bus_b.rise), 32'd0);
        check("async_rst_fall", 32'(bus_a.fall | bus_b.fall), 32'd0);
        check("async_rst_hp", 32'(bus_a.half_period | bus_b.half_period), 32'd0);
        check("async_rst_locked", 32'(bus_a.locked | bus_b.locked), 32'd0);
        check("async_rst_timeout", 32'(bus_a.timeout | bus_b.timeout), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (5) toggle_after(5);
        repeat (4) @(negedge clk);
        check("relock_hp", 32'(bus_a.half_period), 32'd5);
        check("relock_locked", 32'(bus_a.locked), 32'd1);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
